// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: state encoding, opcode constants and branch condition codes
// shared by the fetch/branch control sequencer and its neighbours.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        HAND
    } state_t;

    localparam logic [4:0] OPC_NOP  = 5'b00000;
    localparam logic [4:0] OPC_LD   = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00011;
    localparam logic [4:0] OPC_ADD  = 5'b01100;
    localparam logic [4:0] OPC_BR   = 5'b10010;
    localparam logic [4:0] OPC_BRL  = 5'b10011;
    localparam logic [4:0] OPC_STOP = 5'b11111;

    // C2 field, ir[20:19]; evaluated by the CON flip-flop, not by the sequencer
    typedef enum logic [1:0] {
        C2_ZR = 2'b00,
        C2_NZ = 2'b01,
        C2_PL = 2'b10,
        C2_MI = 2'b11
    } cond_t;

    function automatic logic is_branch(input logic [31:0] ir);
        return ir[31:27] == OPC_BR;
    endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: strobe, handshake and status bundle between the
// sequencer (master) and the datapath / main control unit (slave).
interface branch_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             con;
    logic             mem_rdy;
    logic             exec_done;
    logic [31:0]      ir;
    logic             pc_out, mar_in, inc_pc, z_in, z_lo_out, pc_in, read, mdr_in, mdr_out, ir_in;
    logic             gra, r_out, con_in, y_in, c_out, alu_add;
    logic             exec_req, busy, done, taken, mem_err;
    logic [CNT_W-1:0] br_cnt, tk_cnt;

    modport master (
        input  start, ir, con, mem_rdy, exec_done,
        output pc_out, mar_in, inc_pc, z_in, z_lo_out, pc_in, read, mdr_in, mdr_out, ir_in,
        output gra, r_out, con_in, y_in, c_out, alu_add,
        output exec_req, busy, done, taken, mem_err, br_cnt, tk_cnt
    );

    modport slave (
        output start, ir, con, mem_rdy, exec_done,
        input  pc_out, mar_in, inc_pc, z_in, z_lo_out, pc_in, read, mdr_in, mdr_out, ir_in,
        input  gra, r_out, con_in, y_in, c_out, alu_add,
        input  exec_req, busy, done, taken, mem_err, br_cnt, tk_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!clr_n)
            q <= '0;
        else if (inc && !(&q))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: Moore control sequencer for instruction fetch and the
// conditional branch; other opcodes are handed to the main control unit.
module branch_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input logic                clk,
    input logic                clr_n,
    branch_sequencer_if.master bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_err;
    logic              timeout;
    logic              br_t3;
    logic              tk_t6;

    // last permitted wait cycle with memory still not ready
    assign timeout = !bus.mem_rdy && wait_cnt == WAIT_W'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state   <= T0;
                    mem_err <= 1'b0;
                end
                T0: begin
                    state    <= T1;
                    wait_cnt <= '0;
                end
                T1: if (bus.mem_rdy) begin
                    state <= T2;
                end else if (timeout) begin
                    state   <= IDLE;
                    mem_err <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                T2:      state <= T3;
                T3:      state <= is_branch(bus.ir) ? T4 : HAND;
                T4:      state <= T5;
                T5:      state <= T6;
                T6:      state <= IDLE;
                HAND:    if (bus.exec_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign br_t3 = state == T3 && is_branch(bus.ir);
    assign tk_t6 = state == T6 && bus.con;

    assign bus.pc_out   = state == T0 || state == T4;
    assign bus.mar_in   = state == T0;
    assign bus.inc_pc   = state == T0;
    assign bus.z_in     = state == T0 || state == T5;
    assign bus.z_lo_out = state == T1 || tk_t6;
    assign bus.pc_in    = state == T1 || tk_t6;
    assign bus.read     = state == T1;
    assign bus.mdr_in   = state == T1;
    assign bus.mdr_out  = state == T2;
    assign bus.ir_in    = state == T2;
    assign bus.gra      = br_t3;
    assign bus.r_out    = br_t3;
    assign bus.con_in   = br_t3;
    assign bus.y_in     = state == T4;
    assign bus.c_out    = state == T5;
    assign bus.alu_add  = state == T5;
    assign bus.exec_req = state == HAND;
    assign bus.busy     = state != IDLE;
    assign bus.done     = state == T6 || (state == HAND && bus.exec_done);
    assign bus.taken    = tk_t6;
    assign bus.mem_err  = mem_err;

    sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
        .clk  (clk),
        .clr_n(clr_n),
        .inc  (state == T6),
        .q    (bus.br_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_tk_cnt (
        .clk  (clk),
        .clr_n(clr_n),
        .inc  (tk_t6),
        .q    (bus.tk_cnt)
    );

endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed vector table plus randomized instructions checked
// against per-instruction timing rules; a 2-bit-counter twin checks saturation.
module tb_branch_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int MT = 15;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   nbr = 0;
    int   ntk = 0;

    always #5 clk = ~clk;

    branch_sequencer_if #(.CNT_W(16)) a ();
    branch_sequencer_if #(.CNT_W(2))  b ();

    branch_sequencer #(.CNT_W(16), .MEM_TIMEOUT(MT)) dut_a (.clk(clk), .clr_n(clr_n), .bus(a.master));
    branch_sequencer #(.CNT_W(2),  .MEM_TIMEOUT(MT)) dut_b (.clk(clk), .clr_n(clr_n), .bus(b.master));

    assign b.start     = a.start;
    assign b.ir        = a.ir;
    assign b.con       = a.con;
    assign b.mem_rdy   = a.mem_rdy;
    assign b.exec_done = a.exec_done;

    logic [15:0] stb;
    assign stb = {a.pc_out, a.mar_in, a.inc_pc, a.z_in, a.z_lo_out, a.pc_in, a.read, a.mdr_in,
                  a.mdr_out, a.ir_in, a.gra, a.r_out, a.con_in, a.y_in, a.c_out, a.alu_add};

    typedef struct {
        logic [31:0] ir;
        logic        con;
        int          d;
        int          e;
        bit          hold;
        bit          rst;
        int          done;
        logic        tk;
        logic        err;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [1:0] c2);
        return {op, 6'd0, c2, 19'd0};
    endfunction

    function automatic int sat(input int n, input int w);
        return n > (1 << w) - 1 ? (1 << w) - 1 : n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        a.start = 1'b0;
        clr_n   = 1'b0;
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        #1;
        nbr = 0;
        ntk = 0;
    endtask

    // d: T1 cycles with mem_rdy low; e: HAND cycle in which exec_done rises
    task automatic run(input logic [31:0] ir_v, input logic con_v, input int d, input int e,
                       input bit hold, input int exp_done, input logic exp_tk, input logic exp_err);
        bit   br = ir_v[31:27] == OPC_BR;
        int   limit = exp_err ? 2 + MT : exp_done;
        int   dc = -1;
        int   nreq = 0;
        logic tk = 1'b0;
        logic pin = 1'b0;
        a.start     = 1'b1;
        a.ir        = ir_v;
        a.con       = con_v;
        a.mem_rdy   = 1'b0;
        a.exec_done = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk);
            #1;
            if (!hold) a.start = 1'b0;
            a.mem_rdy   = c >= 2 + d;
            a.exec_done = !br && !exp_err && c == 4 + d + e;
            #1;
            if (c == 1) begin
                chk("t0_strobes", int'({a.pc_out, a.mar_in, a.inc_pc, a.z_in, a.busy}), 31);
                chk("mem_err_cleared_by_start", int'(a.mem_err), 0);
            end
            if (!exp_err && c == 4 + d)
                chk("t3_branch_strobes", int'({a.gra, a.r_out, a.con_in}), br ? 7 : 0);
            chk("single_bus_driver", int'($countones({a.pc_out, a.mdr_out, a.z_lo_out, a.r_out, a.c_out}) <= 1), 1);
            nreq += int'(a.exec_req);
            if (a.done && dc < 0) begin
                dc  = c;
                tk  = a.taken;
                pin = a.pc_in;
            end
        end
        chk("done_cycle", dc, exp_done);
        if (!exp_err) begin
            chk("taken", int'(tk), int'(exp_tk));
            chk("pc_in_at_done", int'(pin), int'(exp_tk));
            @(posedge clk);
            #1;
            a.exec_done = 1'b0;
            #1;
        end
        a.mem_rdy = 1'b0;
        if (!exp_err && br) begin
            nbr++;
            ntk += int'(exp_tk);
        end
        chk("exec_req_cycles", nreq, (!br && !exp_err) ? e : 0);
        chk("idle_after", int'({a.busy, a.done, a.exec_req}), 0);
        chk("mem_err", int'(a.mem_err), int'(exp_err));
        chk("br_cnt", int'(a.br_cnt), sat(nbr, 16));
        chk("tk_cnt", int'(a.tk_cnt), sat(ntk, 16));
        chk("br_cnt_w2", int'(b.br_cnt), sat(nbr, 2));
        chk("tk_cnt_w2", int'(b.tk_cnt), sat(ntk, 2));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [4:0] op;
        int         r, d, e;
        logic       cn;
        bit         hd, isb, er;
        tbl[0]  = '{mk(OPC_BR, C2_ZR),  1'b1, 0,  0, 1'b1, 1'b0, 7,  1'b1, 1'b0};
        tbl[1]  = '{mk(OPC_BR, C2_ZR),  1'b1, 0,  0, 1'b1, 1'b0, 7,  1'b1, 1'b0};
        tbl[2]  = '{mk(OPC_BR, C2_ZR),  1'b1, 0,  0, 1'b1, 1'b0, 7,  1'b1, 1'b0};
        tbl[3]  = '{mk(OPC_BR, C2_ZR),  1'b1, 0,  0, 1'b1, 1'b0, 7,  1'b1, 1'b0};
        tbl[4]  = '{mk(OPC_BR, C2_ZR),  1'b1, 0,  0, 1'b1, 1'b0, 7,  1'b1, 1'b0};
        tbl[5]  = '{mk(OPC_BR, C2_NZ),  1'b0, 0,  0, 1'b0, 1'b1, 7,  1'b0, 1'b0};
        tbl[6]  = '{mk(OPC_BR, C2_ZR),  1'b1, 3,  0, 1'b0, 1'b0, 10, 1'b1, 1'b0};
        tbl[7]  = '{mk(OPC_LD, C2_ZR),  1'b1, 0,  5, 1'b0, 1'b0, 9,  1'b0, 1'b0};
        tbl[8]  = '{mk(OPC_BR, C2_ZR),  1'b1, 15, 0, 1'b0, 1'b0, -1, 1'b0, 1'b1};
        tbl[9]  = '{mk(OPC_BR, C2_MI),  1'b1, 14, 0, 1'b0, 1'b0, 21, 1'b1, 1'b0};
        tbl[10] = '{mk(OPC_BRL, C2_ZR), 1'b0, 2,  1, 1'b0, 1'b0, 7,  1'b0, 1'b0};
        tbl[11] = '{mk(OPC_BR, C2_PL),  1'b0, 16, 0, 1'b0, 1'b0, -1, 1'b0, 1'b1};
        tbl[12] = '{mk(OPC_ADD, C2_ZR), 1'b0, 0,  1, 1'b0, 1'b0, 5,  1'b0, 1'b0};

        a.start = 1'b0; a.ir = '0; a.con = 1'b0; a.mem_rdy = 1'b0; a.exec_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_strobes", int'(stb), 0);
        chk("reset_status", int'({a.busy, a.done, a.taken, a.exec_req, a.mem_err}), 0);
        chk("reset_counters", int'(a.br_cnt) + int'(a.tk_cnt), 0);
        clr_n = 1'b1;
        #1;

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst) do_reset();
            run(tbl[i].ir, tbl[i].con, tbl[i].d, tbl[i].e, tbl[i].hold, tbl[i].done, tbl[i].tk, tbl[i].err);
        end

        for (int i = 0; i < 150; i++) begin
            op  = $urandom_range(1) != 0 ? OPC_BR : 5'($urandom_range(31));
            r   = int'($urandom_range(9));
            d   = r < 6 ? r : MT - 8 + r;
            e   = int'($urandom_range(6, 1));
            cn  = 1'($urandom_range(1));
            hd  = i < 149 && $urandom_range(3) == 0;
            isb = op == OPC_BR;
            er  = d >= MT;
            run(mk(op, 2'($urandom_range(3))), cn, d, e, hd,
                er ? -1 : (isb ? 7 + d : 4 + d + e), isb && cn && !er, er);
        end

        // reset pulse while a branch sits in T4
        a.start = 1'b1; a.ir = mk(OPC_BR, C2_ZR); a.con = 1'b1; a.mem_rdy = 1'b1; a.exec_done = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            a.start = 1'b0;
            #1;
        end
        chk("t4_strobes", int'({a.y_in, a.pc_out}), 3);
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        a.mem_rdy = 1'b0;
        #1;
        chk("mid_reset_strobes", int'(stb), 0);
        chk("mid_reset_status", int'({a.busy, a.done, a.taken, a.exec_req, a.mem_err}), 0);
        chk("mid_reset_br_cnt", int'(a.br_cnt), 0);
        chk("mid_reset_tk_cnt", int'(a.tk_cnt), 0);
        nbr = 0;
        ntk = 0;
        run(mk(OPC_BR, C2_ZR), 1'b1, 0, 0, 1'b0, 7, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
